// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: memory-mapped I/O controller sitting between the execute
// stage of the 3-stage CPU and the UART handshake ports. Decodes the I/O
// window, sequences TX/RX handshakes, stalls the pipeline on blocking
// accesses with a bounded timeout, and provides a free-running cycle counter.
module uart_io_ctrl #(
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [7:0]  StoreData,
  input  logic        DataInReady,
  input  logic        DataOutValid,
  input  logic [7:0]  DataOut,
  output logic        Stall,
  output logic        DataInValid,
  output logic [7:0]  DataIn,
  output logic        DataOutReady,
  output logic [31:0] IoReadData,
  output logic        IoSel,
  output logic        ErrFlag
);

  // Stall counter must be able to hold STALL_LIMIT itself.
  localparam int unsigned SC_W = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT_C = SC_W'(STALL_LIMIT);

  // Register index map inside the I/O window (Address[4:2]).
  localparam logic [2:0] IDX_TX_STAT = 3'd0;
  localparam logic [2:0] IDX_RX_STAT = 3'd1;
  localparam logic [2:0] IDX_RX_DATA = 3'd2;
  localparam logic [2:0] IDX_TX_DATA = 3'd3;
  localparam logic [2:0] IDX_CYCLE   = 3'd4;
  localparam logic [2:0] IDX_ERR     = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TX_WAIT = 2'd1,
    ST_RX_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic              din_valid_q, din_valid_d;
  logic [7:0]        din_q, din_d;
  logic              dout_ready_q, dout_ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              io_sel_q, io_sel_d;
  logic              err_q, err_d;

  logic              io_hit_s;
  logic              io_wr_s;
  logic              io_rd_s;
  logic [2:0]        idx_s;
  logic [31:0]       cyc_ext_s;
  logic              stall_s;

  // Decode: a store wins when MemRead and MemWrite are both asserted.
  assign io_hit_s  = (Address[31:28] == 4'h8);
  assign io_wr_s   = io_hit_s & MemWrite;
  assign io_rd_s   = io_hit_s & MemRead & ~MemWrite;
  assign idx_s     = Address[4:2];
  assign cyc_ext_s = 32'(cyc_cnt_q);

  // Stall is gated by reset so it drops immediately on reset assertion.
  assign Stall        = stall_s & reset;
  assign DataInValid  = din_valid_q;
  assign DataIn       = din_q;
  assign DataOutReady = dout_ready_q;
  assign IoReadData   = rdata_q;
  assign IoSel        = io_sel_q;
  assign ErrFlag      = err_q;

  // Next-state, stall and registered-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    tx_byte_d    = tx_byte_q;
    cyc_cnt_d    = cyc_cnt_q + CNT_W'(1);
    din_valid_d  = 1'b0;
    din_d        = din_q;
    dout_ready_d = 1'b0;
    rdata_d      = rdata_q;
    io_sel_d     = 1'b0;
    err_d        = err_q;
    stall_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (io_wr_s) begin
          case (idx_s)
            IDX_TX_DATA: begin
              if (DataInReady) begin
                din_valid_d = 1'b1;
                din_d       = StoreData;
              end else begin
                stall_s     = 1'b1;
                tx_byte_d   = StoreData;
                stall_cnt_d = SC_W'(1);
                state_d     = ST_TX_WAIT;
              end
            end
            IDX_CYCLE: cyc_cnt_d = '0;
            IDX_ERR:   err_d     = 1'b0;
            default:   ;
          endcase
        end else if (io_rd_s) begin
          case (idx_s)
            IDX_TX_STAT: begin
              rdata_d  = {31'd0, DataInReady};
              io_sel_d = 1'b1;
            end
            IDX_RX_STAT: begin
              rdata_d  = {31'd0, DataOutValid};
              io_sel_d = 1'b1;
            end
            IDX_RX_DATA: begin
              if (DataOutValid) begin
                dout_ready_d = 1'b1;
                rdata_d      = {24'd0, DataOut};
                io_sel_d     = 1'b1;
              end else begin
                stall_s     = 1'b1;
                stall_cnt_d = SC_W'(1);
                state_d     = ST_RX_WAIT;
              end
            end
            IDX_CYCLE: begin
              rdata_d  = cyc_ext_s;
              io_sel_d = 1'b1;
            end
            IDX_ERR: begin
              rdata_d  = {31'd0, err_q};
              io_sel_d = 1'b1;
            end
            default: begin
              rdata_d  = 32'd0;
              io_sel_d = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TX_WAIT: begin
        if (DataInReady) begin
          din_valid_d = 1'b1;
          din_d       = tx_byte_q;
          stall_cnt_d = '0;
          state_d     = ST_IDLE;
        end else if (stall_cnt_q < LIMIT_C) begin
          stall_s     = 1'b1;
          stall_cnt_d = stall_cnt_q + SC_W'(1);
        end else begin
          err_d       = 1'b1;
          stall_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end

      ST_RX_WAIT: begin
        if (DataOutValid) begin
          dout_ready_d = 1'b1;
          rdata_d      = {24'd0, DataOut};
          io_sel_d     = 1'b1;
          stall_cnt_d  = '0;
          state_d      = ST_IDLE;
        end else if (stall_cnt_q < LIMIT_C) begin
          stall_s     = 1'b1;
          stall_cnt_d = stall_cnt_q + SC_W'(1);
        end else begin
          // Aborted load returns all-ones so software can spot the timeout.
          err_d       = 1'b1;
          rdata_d     = 32'hFFFF_FFFF;
          io_sel_d    = 1'b1;
          stall_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        stall_cnt_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      stall_cnt_q  <= '0;
      tx_byte_q    <= 8'd0;
      cyc_cnt_q    <= '0;
      din_valid_q  <= 1'b0;
      din_q        <= 8'd0;
      dout_ready_q <= 1'b0;
      rdata_q      <= 32'd0;
      io_sel_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      tx_byte_q    <= tx_byte_d;
      cyc_cnt_q    <= cyc_cnt_d;
      din_valid_q  <= din_valid_d;
      din_q        <= din_d;
      dout_ready_q <= dout_ready_d;
      rdata_q      <= rdata_d;
      io_sel_q     <= io_sel_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: doc/uart_io_ctrl.md
Name: uart_io_ctrl

Overview:
- Memory-mapped I/O controller between the 3-stage CPU datapath (execute stage address/control) and the UART handshake ports.
- Decodes I/O addresses and sequences UART TX/RX handshakes.
- Stalls the pipeline on a blocking access whose resource is not ready, with a timeout.
- Supplies write-back data for I/O loads and a free-running cycle counter.

Parameters:
- STALL_LIMIT, 1024: max consecutive stall cycles per blocking access before abort; must be >= 1.
- CNT_W, 32: cycle-counter width, <= 32.

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  execute-stage ALU result.
- MemRead  in  1  execute-stage load.
- MemWrite  in  1  execute-stage store.
- StoreData  in  8  execute-stage rt[7:0].
- DataInReady  in  1  UART TX can accept a byte.
- DataOutValid  in  1  UART RX holds a byte.
- DataOut  in  8  UART RX byte.
- Stall  out  1  freeze pipeline (drives datapath Stall).
- DataInValid  out  1  TX strobe, one cycle.
- DataIn  out  8  TX byte.
- DataOutReady  out  1  RX acknowledge, one cycle.
- IoReadData  out  32  write-back data for I/O loads.
- IoSel  out  1  write-back selects IoReadData instead of DMEM.
- ErrFlag  out  1  sticky timeout flag.

Behaviour:
- I/O space is Address[31:28]==4'h8, decoded on Address[4:2]; Address[1:0] is ignored.
  - 0: TX status, read. Value {31'b0, DataInReady}.
  - 1: RX status, read. Value {31'b0, DataOutValid}.
  - 2: RX data, read, blocking.
  - 3: TX data, write, blocking.
  - 4: cycle counter. Read returns the count zero-extended; any write clears it.
  - 5: ErrFlag. Read returns {31'b0, ErrFlag}; any write clears it.
  - 6, 7: reads return 0; writes are ignored.
- Non-I/O addresses: no effect; IoSel=0 in the following cycle.
- All outputs reset to 0. State=IDLE, cycle counter=0, stall counter=0.
- FSM states: IDLE, TX_WAIT, RX_WAIT.
- Stall is combinational, asserted in:
  - IDLE, when a TX-data write is presented with DataInReady=0, or an RX-data read with DataOutValid=0;
  - TX_WAIT/RX_WAIT while the resource stays not ready and the stall counter < STALL_LIMIT.
- IDLE transitions:
  - TX-data write with DataInReady=1: next cycle DataInValid=1 and DataIn=StoreData latched; stay IDLE.
  - TX-data write with DataInReady=0: latch StoreData, go to TX_WAIT, stall counter=1.
  - RX-data read with DataOutValid=1: next cycle DataOutReady=1, IoReadData={24'b0, DataOut}, IoSel=1.
  - RX-data read with DataOutValid=0: go to RX_WAIT, stall counter=1.
  - Status and counter reads: IoReadData and IoSel are registered; valid one cycle after decode, aligned with the datapath write-back stage.
- TX_WAIT/RX_WAIT:
  - On the cycle the resource becomes ready, Stall=0 and the access completes exactly as in IDLE (strobe/data next cycle); return to IDLE.
  - If not ready and the stall counter == STALL_LIMIT: Stall=0, no strobe, ErrFlag<=1. An aborted RX read returns IoReadData=32'hFFFF_FFFF with IoSel=1. Return to IDLE.
  - Otherwise the stall counter increments.
- Address, MemRead and MemWrite are held stable by the stalled pipeline. Controller latches cover StoreData only.
- MemRead and MemWrite both high: treated as a write.
- Strobes (DataInValid, DataOutReady) last exactly one cycle; there is never more than one strobe per access.
- The cycle counter increments every cycle, including stalls, and wraps modulo 2^CNT_W.
  - A clearing write in cycle t gives a read value of 0 at t+1.
  - A simultaneous increment loses to the clear.
- ErrFlag is set only by a timeout and cleared only by reset or a write to index 5. If a set and a clear occur in the same cycle, the set wins.
- Reset assertion mid-access (any state) returns to IDLE immediately, drops Stall, and emits no strobe.

Test Plan:
- TX ready: DataInReady=1; store 8'h41 to 0x8000000C -> Stall stays 0; next cycle DataInValid=1 for exactly one cycle with DataIn=8'h41.
- TX blocked: DataInReady=0 for 5 cycles, then 1 -> Stall high 5 cycles, low on the 6th; one DataInValid pulse the cycle after, DataIn=StoreData as presented; ErrFlag=0.
- RX blocked then valid: load 0x80000008; DataOutValid rises after 3 cycles with DataOut=8'h5A -> Stall high 3 cycles; then DataOutReady pulse, IoReadData=32'h0000005A, IoSel=1.
- Timeout, STALL_LIMIT=4: RX read with DataOutValid stuck low -> Stall high 4 cycles, then IoReadData=32'hFFFFFFFF, ErrFlag=1, no DataOutReady; read 0x80000014 -> 1; write 0x80000014 -> ErrFlag=0.
- Counter: after reset, read 0x80000010 at cycle 10 -> 10; write clears -> next read 1 cycle later returns 0; CNT_W=4 wraps 15->0.
- Reset mid-stall: assert reset low in TX_WAIT -> Stall=0 and all outputs 0 asynchronously; after release, state IDLE and no DataInValid ever issued for the aborted store.
